rast_rect_pixel_sender: RTL and testbench

//  Rasterizer-side transmitter for the DVI framebuffer pixel-write interface.
//  - Accepts axis-aligned rectangle fill commands; clips and normalises each one.
//  - Streams its pixels in row-major order to the framebuffer top level.
//  - Drives rast_pixel_rdy/coords/color and consumes the framebuffer's read_rast_pixel_rdy.
//  - Pulses rast_done once the last command of a frame has been fully written.

---
 rtl/rast_pkg.sv | 26 ++
 rtl/rast_scan_counter.sv | 47 ++++
 rtl/rast_rect_pixel_sender.sv | 140 ++++++++++++++
 tb/tb_rast_rect_pixel_sender.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rast_pkg.sv
// Shared constants and types for the rasterizer rectangle pixel sender.
// Screen geometry, coordinate widths, FSM state encoding and the latched
// rectangle command record live here so the top and the counter agree.
package rast_pkg;

  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int X_W     = 10;
  localparam int Y_W     = 9;
  localparam int COLOR_W = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLIP = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef struct packed {
    logic [X_W-1:0]     x0;
    logic [X_W-1:0]     x1;
    logic [Y_W-1:0]     y0;
    logic [Y_W-1:0]     y1;
    logic [COLOR_W-1:0] color;
    logic               last;
  } rect_cmd_t;

endpackage

// File: rtl/rast_scan_counter.sv
// Row-major x/y scan counter for one clipped rectangle.
// load captures the bounds and starts at (xl,yl); each advance steps x,
// wrapping to xl and stepping y at the right edge. last flags (xh,yh).
module rast_scan_counter
  import rast_pkg::*;
(
  input  logic           clk,
  input  logic           load,
  input  logic           advance,
  input  logic [X_W-1:0] xl,
  input  logic [X_W-1:0] xh,
  input  logic [Y_W-1:0] yl,
  input  logic [Y_W-1:0] yh,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic [X_W-1:0] xl_q;
  logic [X_W-1:0] xh_q;
  logic [Y_W-1:0] yh_q;

  // Bounds are held here so the top only has to present them during load.
  always_ff @(posedge clk) begin
    if (load) begin
      x_q  <= xl;
      y_q  <= yl;
      xl_q <= xl;
      xh_q <= xh;
      yh_q <= yh;
    end else if (advance) begin
      if (x_q == xh_q) begin
        x_q <= xl_q;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xh_q) && (y_q == yh_q);

endmodule

// File: rtl/rast_rect_pixel_sender.sv
// Rasterizer rectangle fill sender for the framebuffer pixel-write port.
// Accepts one rectangle command at a time, normalises and clips it to the
// screen, then streams its pixels row-major with a rdy/read handshake.
// Optional build macro: RAST_CHECKER_EN inverts color on pixels where
// (x^y) is odd, giving a checkerboard fill for bring-up.
module rast_rect_pixel_sender
  import rast_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [X_W-1:0]     cmd_x1,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [Y_W-1:0]     cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_last,
  output logic               rast_pixel_rdy,
  output logic [X_W-1:0]     rast_width,
  output logic [Y_W-1:0]     rast_height,
  output logic [COLOR_W-1:0] rast_color_input,
  input  logic               read_rast_pixel_rdy,
  output logic               rast_done,
  output logic               busy
);

  // One extra bit on the compare side so SCR_W itself is representable.
  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCR_W);
  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCR_W - 1);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCR_H);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCR_H - 1);

  // Saturate a high x corner to the last visible column.
  function automatic logic [X_W-1:0] sat_x(input logic [X_W-1:0] v);
    logic [X_W:0] ext;
    ext = {1'b0, v};
    sat_x = (ext > X_MAX) ? X_MAX[X_W-1:0] : v;
  endfunction

  // Saturate a high y corner to the last visible row.
  function automatic logic [Y_W-1:0] sat_y(input logic [Y_W-1:0] v);
    logic [Y_W:0] ext;
    ext = {1'b0, v};
    sat_y = (ext > Y_MAX) ? Y_MAX[Y_W-1:0] : v;
  endfunction

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  rect_cmd_t          cmd_q;
  logic               accept;
  logic [X_W-1:0]     xl_c;
  logic [X_W-1:0]     xh_c;
  logic [Y_W-1:0]     yl_c;
  logic [Y_W-1:0]     yh_c;
  logic               empty_c;
  logic               emit;
  logic               xfer;
  logic               cnt_load;
  logic [X_W-1:0]     cnt_x;
  logic [Y_W-1:0]     cnt_y;
  logic               cnt_last;
  logic [COLOR_W-1:0] pix_color;

  assign accept = cmd_valid && cmd_ready;
  assign emit   = (state_q == ST_EMIT);
  assign xfer   = emit && read_rast_pixel_rdy;

  // Capture the command on acceptance; it is only consumed after CLIP.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q <= '{x0: cmd_x0, x1: cmd_x1, y0: cmd_y0, y1: cmd_y1,
                 color: cmd_color, last: cmd_last};
    end
  end

  // Normalise corner order, clip the high corner, flag fully off-screen rects.
  always_comb begin
    xl_c    = (cmd_q.x0 < cmd_q.x1) ? cmd_q.x0 : cmd_q.x1;
    xh_c    = sat_x((cmd_q.x0 < cmd_q.x1) ? cmd_q.x1 : cmd_q.x0);
    yl_c    = (cmd_q.y0 < cmd_q.y1) ? cmd_q.y0 : cmd_q.y1;
    yh_c    = sat_y((cmd_q.y0 < cmd_q.y1) ? cmd_q.y1 : cmd_q.y0);
    empty_c = ({1'b0, xl_c} >= X_LIM) || ({1'b0, yl_c} >= Y_LIM);
  end

  assign cnt_load = (state_q == ST_CLIP) && !empty_c;

  rast_scan_counter u_scan (
    .clk     (clk),
    .load    (cnt_load),
    .advance (xfer),
    .xl      (xl_c),
    .xh      (xh_c),
    .yl      (yl_c),
    .yh      (yh_c),
    .x       (cnt_x),
    .y       (cnt_y),
    .last    (cnt_last)
  );

  // Next-state logic: IDLE -> CLIP -> EMIT -> (IDLE | DONE) -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_CLIP;
      ST_CLIP: begin
        if (empty_c) state_d = cmd_q.last ? ST_DONE : ST_IDLE;
        else         state_d = ST_EMIT;
      end
      ST_EMIT: if (xfer && cnt_last) state_d = cmd_q.last ? ST_DONE : ST_IDLE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Per-pixel color, optionally checkerboarded on odd (x^y).
  always_comb begin
`ifdef RAST_CHECKER_EN
    pix_color = cmd_q.color ^ {COLOR_W{cnt_x[0] ^ cnt_y[0]}};
`else
    pix_color = cmd_q.color;
`endif
  end

  assign cmd_ready        = (state_q == ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign rast_pixel_rdy   = emit;
  assign rast_done        = (state_q == ST_DONE);
  // Pixel fields read zero outside EMIT, so the counter needs no reset.
  assign rast_width       = emit ? cnt_x     : '0;
  assign rast_height      = emit ? cnt_y     : '0;
  assign rast_color_input = emit ? pix_color : '0;

endmodule

// File: tb/tb_rast_rect_pixel_sender.sv
// Self-checking bench for rast_rect_pixel_sender: directed corner cases
// plus randomized rectangles checked against a queue-based pixel model.
module tb_rast_rect_pixel_sender;
  import rast_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [X_W-1:0]     cmd_x0, cmd_x1;
  logic [Y_W-1:0]     cmd_y0, cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic               cmd_last;
  logic               rast_pixel_rdy;
  logic [X_W-1:0]     rast_width;
  logic [Y_W-1:0]     rast_height;
  logic [COLOR_W-1:0] rast_color_input;
  logic               read_rast_pixel_rdy;
  logic               rast_done;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  always #5 clk = ~clk;

  rast_rect_pixel_sender dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_x0              (cmd_x0),
    .cmd_x1              (cmd_x1),
    .cmd_y0              (cmd_y0),
    .cmd_y1              (cmd_y1),
    .cmd_color           (cmd_color),
    .cmd_last            (cmd_last),
    .rast_pixel_rdy      (rast_pixel_rdy),
    .rast_width          (rast_width),
    .rast_height         (rast_height),
    .rast_color_input    (rast_color_input),
    .read_rast_pixel_rdy (read_rast_pixel_rdy),
    .rast_done           (rast_done),
    .busy                (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_color(input int x, input int y, input int c);
`ifdef RAST_CHECKER_EN
    if (((x ^ y) & 1) == 1) return (~c) & ((1 << COLOR_W) - 1);
`endif
    return c;
  endfunction

  // Pixels a rectangle should produce, straight from the clipping rules.
  task automatic build_expected(input int x0, input int x1, input int y0, input int y1,
                                input int c, output pix_t q[$]);
    int xl, xh, yl, yh;
    pix_t p;
    q = {};
    xl = (x0 < x1) ? x0 : x1;
    xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;
    yh = (y0 < y1) ? y1 : y0;
    if (xh > SCR_W - 1) xh = SCR_W - 1;
    if (yh > SCR_H - 1) yh = SCR_H - 1;
    if (xl >= SCR_W || yl >= SCR_H) return;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        p.x = x; p.y = y; p.c = exp_color(x, y, c);
        q.push_back(p);
      end
  endtask

  task automatic drive_cmd(input int x0, input int x1, input int y0, input int y1,
                           input int c, input bit last);
    cmd_valid = 1'b1;
    cmd_x0    = X_W'(x0);
    cmd_x1    = X_W'(x1);
    cmd_y0    = Y_W'(y0);
    cmd_y1    = Y_W'(y1);
    cmd_color = COLOR_W'(c);
    cmd_last  = last;
  endtask

  // Runs one command from an idle negedge to the next idle negedge.
  // mode: 0 reader always ready, 1 ready every 3rd cycle, 2 random.
  task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                         input int c, input bit last, input int mode);
    pix_t q[$];
    pix_t p;
    int   total, xfers, k, end_cycle, idle_cycle, budget;
    bit   pend, rd;
    int   hx, hy, hc;
    build_expected(x0, x1, y0, y1, c, q);
    total      = q.size();
    xfers      = 0;
    pend       = 1'b0;
    hx = 0; hy = 0; hc = 0;
    end_cycle  = (total == 0) ? 2 : -1;
    idle_cycle = (total == 0) ? 2 + int'(last) : -1;
    budget     = 4 * total + 20;
    check("cmd_ready_before_accept", int'(cmd_ready), 1);
    drive_cmd(x0, x1, y0, y1, c, last);
    @(negedge clk);
    k = 1;
    check("cmd_ready_in_clip", int'(cmd_ready), 0);
    check("busy_in_clip", int'(busy), 1);
    check("pixel_rdy_in_clip", int'(rast_pixel_rdy), 0);
    // Presented while busy, must be ignored.
    drive_cmd(x0 ^ 5, x1, y0, y1 ^ 3, c ^ 1, !last);
    forever begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      if (k > budget) begin
        check("timeout", 0, 1);
        break;
      end
      check("rast_done", int'(rast_done), int'(last && k == end_cycle));
      if (k == idle_cycle) begin
        check("cmd_ready_after", int'(cmd_ready), 1);
        check("busy_after", int'(busy), 0);
        check("pixel_rdy_after", int'(rast_pixel_rdy), 0);
        check("pixel_count", xfers, total);
        break;
      end
      check("cmd_ready_busy", int'(cmd_ready), 0);
      check("busy_high", int'(busy), 1);
      if (k == 2) check("first_pixel_cycle", int'(rast_pixel_rdy), int'(total > 0));
      case (mode)
        0:       rd = 1'b1;
        1:       rd = (k % 3 == 0);
        default: rd = 1'($urandom_range(0, 1));
      endcase
      read_rast_pixel_rdy = rd;
      if (rast_pixel_rdy) begin
        if (xfers >= total) begin
          check("extra_pixel", 1, 0);
        end else begin
          if (pend) begin
            check("hold_x", int'(rast_width), hx);
            check("hold_y", int'(rast_height), hy);
            check("hold_color", int'(rast_color_input), hc);
          end
          if (rd) begin
            p = q.pop_front();
            check("pix_x", int'(rast_width), p.x);
            check("pix_y", int'(rast_height), p.y);
            check("pix_color", int'(rast_color_input), p.c);
            xfers++;
            pend = 1'b0;
            if (xfers == total) begin
              end_cycle  = k + 1;
              idle_cycle = k + 1 + int'(last);
            end
          end else begin
            pend = 1'b1;
            hx = int'(rast_width); hy = int'(rast_height); hc = int'(rast_color_input);
          end
        end
      end else if (k > 2 && xfers < total) begin
        check("pixel_rdy_gap", 0, 1);
      end
    end
  endtask

  // Reset lands while the 2nd pixel of a 4x4 rect is on the outputs.
  task automatic reset_mid_emit();
    read_rast_pixel_rdy = 1'b1;
    drive_cmd(0, 3, 0, 3, 6, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_first_pixel_rdy", int'(rast_pixel_rdy), 1);
    @(negedge clk);
    check("rst_second_pixel_rdy", int'(rast_pixel_rdy), 1);
    check("rst_second_pixel_x", int'(rast_width), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_pixel_rdy", int'(rast_pixel_rdy), 0);
    check("rst_mid_cmd_ready", int'(cmd_ready), 1);
    check("rst_mid_done", int'(rast_done), 0);
    check("rst_mid_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_quiet_done", int'(rast_done), 0);
      check("rst_quiet_rdy", int'(rast_pixel_rdy), 0);
    end
  endtask

  initial begin
    int xb, x1, yb, y1, t;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0;
    cmd_color = '0; cmd_last = 1'b0;
    read_rast_pixel_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", int'(cmd_ready), 1);
    check("reset_pixel_rdy", int'(rast_pixel_rdy), 0);
    check("reset_done", int'(rast_done), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_width", int'(rast_width), 0);
    check("reset_height", int'(rast_height), 0);
    check("reset_color", int'(rast_color_input), 0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(3, 4, 4, 5, 5, 1'b1, 0);
    run_cmd(3, 4, 4, 5, 5, 1'b1, 1);
    run_cmd(10, 8, 20, 18, 2, 1'b0, 0);
    run_cmd(638, 700, 478, 500, 3, 1'b0, 2);
    run_cmd(650, 660, 10, 12, 1, 1'b1, 0);
    run_cmd(7, 7, 9, 9, 4, 1'b1, 2);
    run_cmd(700, 710, 470, 475, 6, 1'b0, 0);
    reset_mid_emit();
    run_cmd(5, 6, 7, 8, 7, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      xb = $urandom_range(0, 1023);
      x1 = xb + $urandom_range(0, 7);
      if (x1 > 1023) x1 = 1023;
      yb = $urandom_range(0, 511);
      y1 = yb + $urandom_range(0, 7);
      if (y1 > 511) y1 = 511;
      if ($urandom_range(0, 1) == 1) begin t = xb; xb = x1; x1 = t; end
      if ($urandom_range(0, 1) == 1) begin t = yb; yb = y1; y1 = t; end
      run_cmd(xb, x1, yb, y1, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
